// File: rtl/servo_slew_scheduler.sv
// Four-channel servo command slew limiter: once per frame a shared datapath walks each
// channel, moving its command at most STEP_US toward the target. Commands settle 2..5 cycles after FRAME_TICK.
module servo_slew_scheduler #(
    parameter int CLK_HZ    = 25_000_000,
    parameter int FRAME_US  = 20000,
    parameter int STEP_US   = 20,
    parameter int MIN_US    = 650,
    parameter int MAX_US    = 2600,
    parameter int CENTER_US = 1500
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [11:0] TARGET0,
    input  logic [11:0] TARGET1,
    input  logic [11:0] TARGET2,
    input  logic [11:0] TARGET3,
    input  logic [3:0]  TGT_VALID,
    input  logic [3:0]  CENTER_REQ,
    output logic [11:0] CMD0,
    output logic [11:0] CMD1,
    output logic [11:0] CMD2,
    output logic [11:0] CMD3,
    output logic [3:0]  AT_TARGET,
    output logic        FRAME_TICK,
    output logic        BUSY
);

    localparam int FRAME_CYC = (CLK_HZ / 1_000_000) * FRAME_US;
    localparam int CNT_W     = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYC - 1);
    localparam logic [11:0] MIN_V    = 12'(MIN_US);
    localparam logic [11:0] MAX_V    = 12'(MAX_US);
    localparam logic [11:0] CENTER_V = 12'(CENTER_US);
    localparam logic [11:0] STEP_V   = 12'(STEP_US);
    localparam logic signed [12:0] STEP_S = 13'(STEP_US);

    if (FRAME_CYC < 8) begin : g_cfg_check
        $error("servo_slew_scheduler: FRAME_CYC must be at least 8");
    end

    typedef enum logic [2:0] {IDLE, UPD0, UPD1, UPD2, UPD3} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [11:0]       tgt_in [4];
    logic [11:0]       tgt_q  [4];
    logic [11:0]       cmd_q  [4];
    logic              upd_en;
    logic [1:0]        sel;
    logic [11:0]       cmd_sel, tgt_sel, cmd_next;
    logic signed [12:0] diff, diff_abs;

    assign tgt_in[0] = TARGET0;
    assign tgt_in[1] = TARGET1;
    assign tgt_in[2] = TARGET2;
    assign tgt_in[3] = TARGET3;

    assign CMD0 = cmd_q[0];
    assign CMD1 = cmd_q[1];
    assign CMD2 = cmd_q[2];
    assign CMD3 = cmd_q[3];
    assign BUSY = (state_q != IDLE);

    function automatic logic [11:0] clamp_us(input logic [11:0] v);
        if (v < MIN_V)      return MIN_V;
        else if (v > MAX_V) return MAX_V;
        else                return v;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q      <= '0;
            FRAME_TICK <= 1'b0;
        end else begin
            FRAME_TICK <= (cnt_q == CNT_LAST);
            cnt_q      <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        upd_en  = 1'b0;
        sel     = 2'd0;
        case (state_q)
            IDLE: if (FRAME_TICK) state_d = UPD0;
            UPD0: begin upd_en = 1'b1; sel = 2'd0; state_d = UPD1; end
            UPD1: begin upd_en = 1'b1; sel = 2'd1; state_d = UPD2; end
            UPD2: begin upd_en = 1'b1; sel = 2'd2; state_d = UPD3; end
            UPD3: begin upd_en = 1'b1; sel = 2'd3; state_d = IDLE; end
            default: state_d = IDLE;
        endcase
    end

    // Shared slew unit: 13-bit signed difference cannot wrap for 12-bit operands.
    always_comb begin
        cmd_sel  = cmd_q[sel];
        tgt_sel  = tgt_q[sel];
        diff     = $signed({1'b0, tgt_sel}) - $signed({1'b0, cmd_sel});
        diff_abs = diff[12] ? -diff : diff;
        if (diff_abs <= STEP_S) cmd_next = tgt_sel;
        else if (diff[12])      cmd_next = cmd_sel - STEP_V;
        else                    cmd_next = cmd_sel + STEP_V;
    end

    // Sweep reads tgt_q before this edge's load, so a same-cycle load waits a frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                cmd_q[i] <= CENTER_V;
                tgt_q[i] <= CENTER_V;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (upd_en && (sel == 2'(i))) cmd_q[i] <= cmd_next;
                if (CENTER_REQ[i])            tgt_q[i] <= CENTER_V;
                else if (TGT_VALID[i])        tgt_q[i] <= clamp_us(tgt_in[i]);
            end
        end
    end

    always_comb begin
        AT_TARGET = '0;
        for (int i = 0; i < 4; i++) AT_TARGET[i] = (cmd_q[i] == tgt_q[i]);
    end

endmodule

// File: tb/tb_servo_slew_scheduler.sv
// Bench for servo_slew_scheduler with a 20-cycle frame: table of per-frame loads and
// expected commands, plus hand sequences for latency, mid-sweep loads, clamping and reset.
module tb_servo_slew_scheduler;

    logic        CLK = 1'b0;
    logic        RST;
    logic [11:0] TARGET0, TARGET1, TARGET2, TARGET3;
    logic [3:0]  TGT_VALID, CENTER_REQ;
    logic [11:0] CMD0, CMD1, CMD2, CMD3;
    logic [3:0]  AT_TARGET;
    logic        FRAME_TICK, BUSY;

    servo_slew_scheduler #(
        .CLK_HZ(1_000_000), .FRAME_US(20), .STEP_US(20),
        .MIN_US(650), .MAX_US(2600), .CENTER_US(1500)
    ) dut (
        .CLK(CLK), .RST(RST),
        .TARGET0(TARGET0), .TARGET1(TARGET1), .TARGET2(TARGET2), .TARGET3(TARGET3),
        .TGT_VALID(TGT_VALID), .CENTER_REQ(CENTER_REQ),
        .CMD0(CMD0), .CMD1(CMD1), .CMD2(CMD2), .CMD3(CMD3),
        .AT_TARGET(AT_TARGET), .FRAME_TICK(FRAME_TICK), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  tv;
        logic [3:0]  cr;
        logic [11:0] t0, t1, t2, t3;
        logic [3:0]  at_pre;
        logic [11:0] e0, e1, e2, e3;
        logic [3:0]  at;
    } vec_t;

    typedef struct {
        logic [11:0] c0, c1, c2, c3;
        logic [3:0]  at;
    } exp_t;

    vec_t vt[12];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!FRAME_TICK && n < 100);
        if (!FRAME_TICK) chk("frame_tick_timeout", 0, 1);
    endtask

    task automatic frame_done();
        wait_tick();
        repeat (5) @(negedge CLK);
    endtask

    task automatic load(input logic [3:0] tv, input logic [3:0] cr,
                        input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] c, input logic [11:0] d);
        TGT_VALID = tv; CENTER_REQ = cr;
        TARGET0 = a; TARGET1 = b; TARGET2 = c; TARGET3 = d;
        @(negedge CLK);
        TGT_VALID = '0; CENTER_REQ = '0;
    endtask

    task automatic count_to_tick(input string nm);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!FRAME_TICK && n < 100);
        chk(nm, n, 20);
    endtask

    initial begin
        exp_t e;
        int   busy_cnt, tick_at, prev, d;

        vt[0]  = '{4'b0001, 4'b0000, 12'd1600, 12'd0,    12'd0,    12'd0,    4'b1110, 12'd1520, 12'd1500, 12'd1500, 12'd1500, 4'b1110};
        vt[1]  = '{4'b0000, 4'b0000, 12'd0,    12'd0,    12'd0,    12'd0,    4'b1110, 12'd1540, 12'd1500, 12'd1500, 12'd1500, 4'b1110};
        vt[2]  = '{4'b0000, 4'b0000, 12'd0,    12'd0,    12'd0,    12'd0,    4'b1110, 12'd1560, 12'd1500, 12'd1500, 12'd1500, 4'b1110};
        vt[3]  = '{4'b0000, 4'b0000, 12'd0,    12'd0,    12'd0,    12'd0,    4'b1110, 12'd1580, 12'd1500, 12'd1500, 12'd1500, 4'b1110};
        vt[4]  = '{4'b0000, 4'b0000, 12'd0,    12'd0,    12'd0,    12'd0,    4'b1110, 12'd1600, 12'd1500, 12'd1500, 12'd1500, 4'b1111};
        vt[5]  = '{4'b0010, 4'b0000, 12'd0,    12'd3000, 12'd0,    12'd0,    4'b1101, 12'd1600, 12'd1520, 12'd1500, 12'd1500, 4'b1101};
        vt[6]  = '{4'b1100, 4'b0000, 12'd0,    12'd0,    12'd1510, 12'd1480, 4'b0001, 12'd1600, 12'd1540, 12'd1510, 12'd1480, 4'b1101};
        vt[7]  = '{4'b0010, 4'b0000, 12'd0,    12'd100,  12'd0,    12'd0,    4'b1101, 12'd1600, 12'd1520, 12'd1510, 12'd1480, 4'b1101};
        vt[8]  = '{4'b0000, 4'b0000, 12'd0,    12'd0,    12'd0,    12'd0,    4'b1101, 12'd1600, 12'd1500, 12'd1510, 12'd1480, 4'b1101};
        vt[9]  = '{4'b0011, 4'b0010, 12'd1580, 12'd2000, 12'd0,    12'd0,    4'b1110, 12'd1580, 12'd1500, 12'd1510, 12'd1480, 4'b1111};
        vt[10] = '{4'b0001, 4'b0000, 12'd500,  12'd0,    12'd0,    12'd0,    4'b1110, 12'd1560, 12'd1500, 12'd1510, 12'd1480, 4'b1110};
        vt[11] = '{4'b0000, 4'b0001, 12'd0,    12'd0,    12'd0,    12'd0,    4'b1110, 12'd1540, 12'd1500, 12'd1510, 12'd1480, 4'b1110};

        RST = 1'b1; TGT_VALID = '0; CENTER_REQ = '0;
        TARGET0 = '0; TARGET1 = '0; TARGET2 = '0; TARGET3 = '0;
        repeat (3) @(negedge CLK);
        chk("rst_cmd0", CMD0, 1500);
        chk("rst_cmd3", CMD3, 1500);
        chk("rst_at_target", AT_TARGET, 4'b1111);
        chk("rst_busy", BUSY, 0);
        chk("rst_tick", FRAME_TICK, 0);
        RST = 1'b0;

        // Idle frames: tick spacing, BUSY width, commands hold at centre.
        count_to_tick("first_tick_delay");
        busy_cnt = 0; tick_at = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (BUSY) busy_cnt++;
            if (FRAME_TICK && tick_at == 0) tick_at = k;
        end
        chk("busy_cycles", busy_cnt, 4);
        chk("tick_period", tick_at, 20);
        repeat (5) @(negedge CLK);
        chk("idle_cmd1", CMD1, 1500);
        chk("idle_cmd2", CMD2, 1500);
        chk("idle_at_target", AT_TARGET, 4'b1111);

        for (int i = 0; i < 12; i++) begin
            e = '{vt[i].e0, vt[i].e1, vt[i].e2, vt[i].e3, vt[i].at};
            sb.push_back(e);
            load(vt[i].tv, vt[i].cr, vt[i].t0, vt[i].t1, vt[i].t2, vt[i].t3);
            chk($sformatf("v%0d_at_pre", i), AT_TARGET, vt[i].at_pre);
            frame_done();
            e = sb.pop_front();
            chk($sformatf("v%0d_cmd0", i), CMD0, e.c0);
            chk($sformatf("v%0d_cmd1", i), CMD1, e.c1);
            chk($sformatf("v%0d_cmd2", i), CMD2, e.c2);
            chk($sformatf("v%0d_cmd3", i), CMD3, e.c3);
            chk($sformatf("v%0d_at", i), AT_TARGET, e.at);
        end

        // Per-channel latency after FRAME_TICK.
        load(4'b1000, 4'b0000, 12'd0, 12'd0, 12'd0, 12'd1520);
        wait_tick();
        chk("lat_busy_T", BUSY, 0);
        @(negedge CLK);
        chk("lat_busy_T1", BUSY, 1);
        chk("lat_cmd0_T1", CMD0, 1540);
        @(negedge CLK);
        chk("lat_cmd0_T2", CMD0, 1520);
        repeat (2) @(negedge CLK);
        chk("lat_cmd3_T4", CMD3, 1480);
        chk("lat_busy_T4", BUSY, 1);
        @(negedge CLK);
        chk("lat_cmd3_T5", CMD3, 1500);
        chk("lat_busy_T5", BUSY, 0);

        // Load on channel 2 landing in its own UPD2 cycle.
        wait_tick();
        repeat (3) @(negedge CLK);
        load(4'b0100, 4'b0000, 12'd0, 12'd0, 12'd1600, 12'd0);
        chk("upd2_load_cmd2_held", CMD2, 1510);
        chk("upd2_load_at2", AT_TARGET[2], 0);
        chk("upd2_load_cmd0", CMD0, 1500);
        repeat (2) @(negedge CLK);
        frame_done();
        chk("upd2_load_next_frame", CMD2, 1530);

        // Clamp at MAX, then reverse toward MIN.
        load(4'b0010, 4'b0000, 12'd0, 12'd3000, 12'd0, 12'd0);
        prev = 1500;
        for (int f = 0; f < 58; f++) begin
            frame_done();
            d = int'(CMD1) - prev;
            chk("cmd1_up_step", (CMD1 >= 650 && CMD1 <= 2600 && d >= 0 && d <= 20) ? 1 : 0, 1);
            prev = int'(CMD1);
        end
        chk("cmd1_hi_clamp", CMD1, 2600);
        load(4'b0010, 4'b0000, 12'd0, 12'd100, 12'd0, 12'd0);
        frame_done();
        chk("cmd1_reverse", CMD1, 2580);
        prev = 2580;
        for (int f = 0; f < 99; f++) begin
            frame_done();
            d = prev - int'(CMD1);
            chk("cmd1_down_step", (CMD1 >= 650 && CMD1 <= 2600 && d >= 0 && d <= 20) ? 1 : 0, 1);
            prev = int'(CMD1);
        end
        chk("cmd1_lo_clamp", CMD1, 650);

        // Reset asserted in the UPD2 cycle.
        load(4'b0001, 4'b0000, 12'd1700, 12'd0, 12'd0, 12'd0);
        for (int f = 0; f < 11; f++) frame_done();
        chk("pre_rst_cmd0", CMD0, 1700);
        wait_tick();
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("midrst_cmd0", CMD0, 1500);
        chk("midrst_cmd1", CMD1, 1500);
        chk("midrst_cmd2", CMD2, 1500);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_at", AT_TARGET, 4'b1111);
        @(negedge CLK);
        RST = 1'b0;
        count_to_tick("post_rst_tick_delay");
        repeat (5) @(negedge CLK);
        chk("post_rst_cmd0", CMD0, 1500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/servo_slew_scheduler.md
SERVO_SLEW_SCHEDULER -- requirements
Module: servo_slew_scheduler

Interface
REQ-001 Parameter CLK_HZ, default 25_000_000, input clock frequency in Hz.
REQ-002 Parameter FRAME_US, default 20000, servo frame period in microseconds.
REQ-003 Parameter STEP_US, default 20, maximum per-frame change of any command in microseconds.
REQ-004 Parameter MIN_US, default 650, lowest legal pulse width in microseconds.
REQ-005 Parameter MAX_US, default 2600, highest legal pulse width in microseconds.
REQ-006 Parameter CENTER_US, default 1500, centre/reset pulse width in microseconds.
REQ-007 CLK  in  1  single system clock; all logic on rising edge.
REQ-008 RST  in  1  asynchronous, active-high reset.
REQ-009 TARGET0..TARGET3  in  12 each  requested pulse width per channel (us, unsigned).
REQ-010 TGT_VALID  in  4  bit i loads TARGETi into channel i target register.
REQ-011 CENTER_REQ  in  4  bit i forces channel i target to CENTER_US.
REQ-012 CMD0..CMD3  out  12 each  current slewed pulse-width command (us) for the servo PWM generators.
REQ-013 AT_TARGET  out  4  bit i high when CMDi equals channel i target register.
REQ-014 FRAME_TICK  out  1  one-cycle pulse marking start of each update sweep.
REQ-015 BUSY  out  1  high while the shared update datapath is sweeping channels.

Function
REQ-016 Frame counter SHALL count 0..FRAME_CYC-1 then wrap, FRAME_CYC = (CLK_HZ/1_000_000)*FRAME_US; FRAME_TICK SHALL be registered high exactly in the cycle after the counter holds FRAME_CYC-1.
REQ-017 FRAME_CYC SHALL be >= 8; smaller values are illegal configuration.
REQ-018 FSM states: IDLE, UPD0, UPD1, UPD2, UPD3; IDLE->UPD0 on the FRAME_TICK cycle, UPDi->UPDi+1 unconditionally, UPD3->IDLE.
REQ-019 BUSY SHALL be high exactly in UPD0..UPD3 (4 cycles per frame).
REQ-020 One shared subtract/compare unit SHALL serve all channels; in UPDi it processes only channel i.
REQ-021 In UPDi: if |target_i - CMDi| <= STEP_US then CMDi <= target_i; else CMDi <= CMDi + STEP_US toward target_i; CMDi changes only in its UPD state.
REQ-022 Difference SHALL be computed signed, 13 bits, with no wrap; CMD always stays within [MIN_US, MAX_US].
REQ-023 Latency: FRAME_TICK in cycle T -> UPD0 in T+1 -> new CMDi visible in cycle T+2+i.
REQ-024 On TGT_VALID[i], target_i <= TARGETi clamped: < MIN_US -> MIN_US, > MAX_US -> MAX_US.
REQ-025 CENTER_REQ[i] and TGT_VALID[i] in the same cycle: CENTER_REQ wins, target_i <= CENTER_US.
REQ-026 A target load landing in the same cycle as UPDi for that channel SHALL be used by the next frame's sweep only; UPDi uses the pre-load target.
REQ-027 Target loads SHALL be accepted in every cycle, including during BUSY; channels load independently and simultaneously.
REQ-028 AT_TARGET[i] SHALL be combinational compare of registered CMDi and target_i.
REQ-029 The block SHALL never move a CMD by more than STEP_US within one frame.

Reset
REQ-030 While RST high: CMD0..3 = CENTER_US, all targets = CENTER_US, frame counter = 0, FSM = IDLE, FRAME_TICK = 0, BUSY = 0, AT_TARGET = 4'b1111.
REQ-031 RST asserted mid-sweep SHALL abort the sweep immediately; after release the first FRAME_TICK occurs FRAME_CYC cycles later.

Verification (sim params CLK_HZ=1_000_000, FRAME_US=20, STEP_US=20; FRAME_CYC=20)
REQ-032 Reset release, no loads -> CMD0..3 = 1500, AT_TARGET = 1111, FRAME_TICK every 20 cycles, BUSY 4 cycles each, CMDs unchanged.
REQ-033 TGT_VALID[0] with TARGET0=1600 -> AT_TARGET[0]=0; CMD0 = 1520,1540,1560,1580,1600 after ticks 1..5; AT_TARGET[0]=1 after tick 5; CMD1..3 stay 1500.
REQ-034 TARGET1=3000 -> target 2600, CMD1 rises 20/frame; then TARGET1=100 -> target 650, CMD1 reverses direction at 20/frame; never outside 650..2600.
REQ-035 TARGET2=1510 -> CMD2 = 1510 after one tick (residual < STEP); TARGET3=1480 -> CMD3 = 1480 after one tick.
REQ-036 CENTER_REQ[1] and TGT_VALID[1] (TARGET1=2000) same cycle -> target stays 1500, CMD1 unchanged; load on channel 2 during its UPD2 cycle -> applied next frame only.
REQ-037 Drive CMD0 to 1700, assert RST in the UPD2 cycle -> all CMD=1500, BUSY=0 in the same cycle; next FRAME_TICK 20 cycles after release.
